// File: rtl/serial_adder_seq.sv
// Bit-serial add sequencer: feeds an external 1-bit full adder LSB first and
// assembles the WIDTH-bit sum and final carry behind a start/busy/done handshake.
module serial_adder_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_s,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr, sum_nxt;
  logic             carry_q;
  logic [CW-1:0]    cnt;

  // Sum bits enter at the MSB so after WIDTH shifts bit 0 lands at sum[0].
  generate
    if (WIDTH == 1) begin : g_w1
      assign sum_nxt = fa_s;
    end else begin : g_wn
      assign sum_nxt = {fa_s, sum_sr[WIDTH-1:1]};
    end
  endgenerate

  assign busy   = (state == RUN);
  assign done   = (state == DONE);
  assign fa_a   = busy & a_sr[0];
  assign fa_b   = busy & b_sr[0];
  assign fa_cin = busy & carry_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      sum_sr  <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr    <= a_in;
            b_sr    <= b_in;
            carry_q <= cin_in;
            cnt     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          sum_sr  <= sum_nxt;
          carry_q <= fa_cout;
          // The final bit's S/Cout go straight into the result registers.
          if (cnt == LAST) begin
            sum   <= sum_nxt;
            cout  <= fa_cout;
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_seq.sv
// Scoreboard bench for serial_adder_seq at WIDTH 8, 16 and 1, each DUT wired to
// a behavioural full adder; expected sums come from plain integer addition.
module tb_serial_adder_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // ---------------- WIDTH=8 ----------------
  logic       s8, cin8, fa_a8, fa_b8, fa_c8, fs8, fco8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  assign fs8  = fa_a8 ^ fa_b8 ^ fa_c8;
  assign fco8 = (fa_a8 & fa_b8) | (fa_c8 & (fa_a8 | fa_b8));
  serial_adder_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(s8), .a_in(a8), .b_in(b8), .cin_in(cin8),
    .fa_a(fa_a8), .fa_b(fa_b8), .fa_cin(fa_c8), .fa_s(fs8), .fa_cout(fco8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));

  // ---------------- WIDTH=16 ----------------
  logic        s16, cin16, fa_a16, fa_b16, fa_c16, fs16, fco16, busy16, done16, cout16;
  logic [15:0] a16, b16, sum16;
  assign fs16  = fa_a16 ^ fa_b16 ^ fa_c16;
  assign fco16 = (fa_a16 & fa_b16) | (fa_c16 & (fa_a16 | fa_b16));
  serial_adder_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(s16), .a_in(a16), .b_in(b16), .cin_in(cin16),
    .fa_a(fa_a16), .fa_b(fa_b16), .fa_cin(fa_c16), .fa_s(fs16), .fa_cout(fco16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16));

  // ---------------- WIDTH=1 ----------------
  logic       s1, cin1, fa_a1, fa_b1, fa_c1, fs1, fco1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;
  assign fs1  = fa_a1 ^ fa_b1 ^ fa_c1;
  assign fco1 = (fa_a1 & fa_b1) | (fa_c1 & (fa_a1 | fa_b1));
  serial_adder_seq #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(s1), .a_in(a1), .b_in(b1), .cin_in(cin1),
    .fa_a(fa_a1), .fa_b(fa_b1), .fa_cin(fa_c1), .fa_s(fs1), .fa_cout(fco1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1));

  // ---------------- scoreboards ----------------
  logic [8:0]  q8[$];
  logic [16:0] q16[$];
  logic [1:0]  q1[$];
  logic [8:0]  last8  = '0;
  logic [16:0] last16 = '0;
  logic [1:0]  last1  = '0;
  logic        dd8 = 1'b0, dd16 = 1'b0, dd1 = 1'b0;

  // Result must match the queued expectation on done and hold otherwise.
  always @(negedge clk) begin
    if (rst) begin
      q8.delete(); last8 = '0; dd8 = 1'b0;
    end else begin
      if (done8) begin
        chk("done8_width", 64'(dd8), 64'(0));
        if (q8.size() == 0) fail("done8_unexpected");
        else begin
          last8 = q8.pop_front();
          chk("sum8", 64'({cout8, sum8}), 64'(last8));
        end
      end else chk("hold8", 64'({cout8, sum8}), 64'(last8));
      dd8 = done8;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q16.delete(); last16 = '0; dd16 = 1'b0;
    end else begin
      if (done16) begin
        chk("done16_width", 64'(dd16), 64'(0));
        if (q16.size() == 0) fail("done16_unexpected");
        else begin
          last16 = q16.pop_front();
          chk("sum16", 64'({cout16, sum16}), 64'(last16));
        end
      end else chk("hold16", 64'({cout16, sum16}), 64'(last16));
      dd16 = done16;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q1.delete(); last1 = '0; dd1 = 1'b0;
    end else begin
      if (done1) begin
        chk("done1_width", 64'(dd1), 64'(0));
        if (q1.size() == 0) fail("done1_unexpected");
        else begin
          last1 = q1.pop_front();
          chk("sum1", 64'({cout1, sum1}), 64'(last1));
        end
      end else chk("hold1", 64'({cout1, sum1}), 64'(last1));
      dd1 = done1;
    end
  end

  // ---------------- drivers (call with the DUT idle) ----------------
  // hold>0 keeps start high with junk operands for that many RUN cycles.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     input bit detail, input int hold);
    int k;
    logic [7:0] m;
    logic [8:0] cy;
    @(posedge clk); #1;
    s8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    q8.push_back(9'(a) + 9'(b) + 9'(c));
    @(posedge clk); #1;
    s8 = (hold > 0);
    a8 = (hold > 0) ? 8'h01 : 8'($urandom);
    b8 = (hold > 0) ? 8'h01 : 8'($urandom);
    cin8 = 1'($urandom);
    k = 0;
    do begin
      @(negedge clk); k++;
      if (k >= hold) s8 = 1'b0;
      if (detail && k <= 8) begin
        m  = 8'((9'd1 << (k - 1)) - 9'd1);
        cy = {1'b0, a & m} + {1'b0, b & m} + 9'(c);
        chk("busy8", 64'(busy8), 64'(1));
        chk("fa_a8", 64'(fa_a8), 64'(a[k-1]));
        chk("fa_b8", 64'(fa_b8), 64'(b[k-1]));
        chk("fa_cin8", 64'(fa_c8), 64'(cy[k-1]));
      end
    end while (!done8 && k < 40);
    chk("lat8", 64'(k), 64'(9));
    if (detail) chk("busy8_in_done", 64'(busy8), 64'(0));
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c, input int hold);
    int k;
    @(posedge clk); #1;
    s16 = 1'b1; a16 = a; b16 = b; cin16 = c;
    q16.push_back(17'(a) + 17'(b) + 17'(c));
    @(posedge clk); #1;
    s16 = (hold > 0);
    a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
    k = 0;
    do begin
      @(negedge clk); k++;
      if (k >= hold) s16 = 1'b0;
    end while (!done16 && k < 60);
    chk("lat16", 64'(k), 64'(17));
  endtask

  task automatic op1(input logic a, input logic b, input logic c);
    int k;
    @(posedge clk); #1;
    s1 = 1'b1; a1 = a; b1 = b; cin1 = c;
    q1.push_back(2'(a) + 2'(b) + 2'(c));
    @(posedge clk); #1;
    s1 = 1'b0; a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
    k = 0;
    do begin
      @(negedge clk); k++;
    end while (!done1 && k < 20);
    chk("lat1", 64'(k), 64'(2));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k, prev;
    s8 = 0; a8 = '0; b8 = '0; cin8 = 0;
    s16 = 0; a16 = '0; b16 = '0; cin16 = 0;
    s1 = 0; a1 = '0; b1 = '0; cin1 = 0;

    #12;
    chk("rst_sum8", 64'({cout8, sum8}), 64'(0));
    chk("rst_ctl8", 64'({busy8, done8, fa_a8, fa_b8, fa_c8}), 64'(0));
    chk("rst_sum16", 64'({cout16, sum16}), 64'(0));
    chk("rst_ctl16", 64'({busy16, done16, fa_a16, fa_b16, fa_c16}), 64'(0));
    chk("rst_sum1", 64'({cout1, sum1}), 64'(0));
    chk("rst_ctl1", 64'({busy1, done1, fa_a1, fa_b1, fa_c1}), 64'(0));
    rst = 1'b0;

    // Directed WIDTH=8 cases with per-bit adder-input checks.
    op8(8'h5A, 8'h3C, 1'b0, 1, 0);
    op8(8'hFF, 8'h01, 1'b0, 1, 0);
    op8(8'hFF, 8'hFF, 1'b1, 1, 0);

    // Start re-asserted during RUN with different operands must be ignored.
    op8(8'h10, 8'h20, 1'b0, 1, 5);
    repeat (4) @(negedge clk);

    // Start held high: one accept every 10 cycles, 1-cycle done pulses.
    @(posedge clk); #1;
    s8 = 1'b1; a8 = 8'h03; b8 = 8'h04; cin8 = 1'b0;
    q8.push_back(9'h007);
    prev = 0;
    for (int j = 0; j < 3; j++) begin
      k = 0;
      do begin @(negedge clk); k++; end while (!done8 && k < 30);
      if (!done8) fail("held_start_timeout");
      if (j > 0) chk("period8", 64'(cyc - prev), 64'(10));
      prev = cyc;
      if (j < 2) q8.push_back(9'h007);
      else s8 = 1'b0;
    end

    // Asynchronous reset after bit 3 of an add.
    @(posedge clk); #1;
    s8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
    q8.push_back(9'h046);
    @(posedge clk); #1;
    s8 = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_sum8", 64'({cout8, sum8}), 64'(0));
    chk("arst_ctl8", 64'({busy8, done8, fa_a8, fa_b8, fa_c8}), 64'(0));
    @(negedge clk); #2 rst = 1'b0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      chk("no_done_after_rst8", 64'({busy8, done8}), 64'(0));
    end
    op8(8'h80, 8'h80, 1'b0, 1, 0);

    // Randomised traffic on all widths in parallel.
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          op8(8'($urandom), 8'($urandom), 1'($urandom), 0, $urandom_range(0, 7));
        end
      end
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          op16(16'($urandom), 16'($urandom), 1'($urandom), $urandom_range(0, 15));
        end
      end
      begin
        op1(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 50; i++) op1(1'($urandom), 1'($urandom), 1'($urandom));
      end
    join

    repeat (3) @(negedge clk);
    chk("q8_drained", 64'(q8.size()), 64'(0));
    chk("q16_drained", 64'(q16.size()), 64'(0));
    chk("q1_drained", 64'(q1.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_adder_seq.md
Name: serial_adder_seq

Overview:
- Bit-serial addition sequencer that sits directly upstream and downstream of the team's 1-bit full_adder cell.
- Accepts two WIDTH-bit operands plus carry-in, then drives the full adder one bit per clock, LSB first.
- Captures the full adder's S/Cout each cycle, holds the running carry in a flip-flop, and assembles the WIDTH-bit sum and final carry-out.
- Presents the result with a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- start  input  1  request; sampled only in IDLE
- a_in  input  WIDTH  operand A, sampled with accepted start
- b_in  input  WIDTH  operand B, sampled with accepted start
- cin_in  input  1  carry-in, sampled with accepted start
- fa_a  output  1  to full_adder A
- fa_b  output  1  to full_adder B
- fa_cin  output  1  to full_adder Cin
- fa_s  input  1  from full_adder S
- fa_cout  input  1  from full_adder Cout
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse, result valid
- sum  output  WIDTH  registered result
- cout  output  1  registered final carry

Behaviour:
- Reset (async, any state): state=IDLE; a_sr, b_sr, sum_sr, carry_q, bit counter, sum, cout, busy, done all 0. The fa_* outputs are 0.
- States: IDLE, RUN, DONE.
  - IDLE: if start=1 at edge, load a_sr<=a_in, b_sr<=b_in, carry_q<=cin_in, cnt<=0, go to RUN. Otherwise stay.
  - RUN: busy=1. Combinationally fa_a=a_sr[0], fa_b=b_sr[0], fa_cin=carry_q. At each edge:
    - a_sr, b_sr shift right, zero-fill.
    - sum_sr shifts right with fa_s into the MSB.
    - carry_q<=fa_cout.
    - cnt<=cnt+1.
  - RUN exit: on the edge where cnt==WIDTH-1, also load sum<={fa_s, sum_sr[WIDTH-1:1]} (for WIDTH=1, sum<=fa_s), load cout<=fa_cout, and go to DONE.
  - DONE: done=1 for exactly this cycle; busy=0. Next edge goes to IDLE.
- fa_a/fa_b/fa_cin are 0 outside RUN.
- The full adder is combinational. fa_s/fa_cout are consumed in the same cycle they are driven; no extra pipeline stage.
- Latency: start accepted at edge E0 → RUN cycles between E0..E(WIDTH) → done high in the cycle after E(WIDTH). Next start can be accepted at edge E(WIDTH+2), so throughput is one add per WIDTH+2 cycles.
- sum/cout hold the last result until the next completion. They do not change during RUN and are not cleared by start.
- start while busy or in DONE: ignored, with no effect on the operation in flight. It is not queued.
- cnt width: clog2(WIDTH)+1; cnt never exceeds WIDTH-1.
- Arithmetic: {cout,sum} == a_in + b_in + cin_in, modulo 2^(WIDTH+1).
- Reset mid-RUN: operation aborts, no done pulse, sum/cout return to 0.
- Operands changing after acceptance: no effect; values are latched.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, cin=0, start pulse → busy high 8 cycles; done pulse at cycle 9 after accept; sum=0x96, cout=0.
- WIDTH=8, a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1. Check fa_cin toggles per bit as expected.
- Start re-asserted during RUN with a=0x01, b=0x01 → ignored; first result (0x10+0x20=0x30) delivered; sum stays 0x30 until the next accepted start completes.
- Start held high continuously with a=0x03, b=0x04 → accepts every WIDTH+2=10 cycles; each done pulse exactly 1 cycle wide; sum=0x07.
- rst asserted asynchronously mid-RUN (after bit 3) → all outputs 0 immediately, state IDLE, no done. A subsequent add of 0x80+0x80 → sum=0x00, cout=1.
- WIDTH=1: a=1, b=1, cin=1 → one RUN cycle; sum=1, cout=1; done on 2nd cycle after accept.
- Randomized: 1000 random operand sets at WIDTH=8 and WIDTH=16, each checked against a+b+cin.
